key_scan_ctrl: RTL and testbench
================================

# key_scan_ctrl

Keyboard scan controller for the POKEY keyboard path. Generates the keyboard scan strobe (`keybClk`) and `SKCTLS` configuration for the keyboard scan core, then captures its key and break events into the KBCODE register, the IRQST keyboard/break bits and the SKSTAT key/overrun bits. Sits between the CPU register decode and the keyboard scan core; drives the combined keyboard interrupt request.

## Interface
- `SCAN_DIV`, 114: `enn` ticks per scan step, i.e. per `keybClk` pulse; legal range 4..255.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `nReset`  in  1  reset, asynchronous, active-low.
- `enn`  in  1  1.79 MHz phase tick, one `clk` wide; qualifies all event sampling and scan counting.
- `wrSkctl`  in  1  one-`clk` strobe: SKCTL write with `din`.
- `wrIrqen`  in  1  one-`clk` strobe: IRQEN write with `din`.
- `wrSkres`  in  1  one-`clk` strobe: SKRES write; data ignored.
- `din`  in  8  CPU write data.
- `setKey`  in  1  key-accepted event from the scan core.
- `setBreak`  in  1  break-key event from the scan core.
- `keyDown`  in  1  key-held status from the scan core.
- `kbD`  in  8  key code from the scan core, valid when `setKey` is sampled.
- `keybClk`  out  1  scan strobe to the scan core.
- `SKCTLS`  out  2  SKCTL[1:0]: bit0 = debounce enable, bit1 = scan enable.
- `kbcode`  out  8  KBCODE register.
- `nIrqst`  out  2  IRQST[7:6], active-low pending: bit1 = break, bit0 = key.
- `nSkstat`  out  2  bit1 = SKSTAT[5] overrun (active-low); bit0 = SKSTAT[2] key down (active-low).
- `nIrq`  out  1  active-low interrupt: low when either `nIrqst` bit is 0.

## Operation
- Reset values:
  - `keybClk` = 0, `SKCTLS` = 00, `kbcode` = 8'h00.
  - `nIrqst` = 11, `nSkstat` = 11, `nIrq` = 1.
  - IRQEN[7:6] = 00, scan counter = 0.
- SKCTL write: `SKCTLS` <= `din[1:0]` on the strobe edge.
- IRQEN write: stores `din[7:6]`. Any enable bit written 0 clears its pending bit (the `nIrqst` bit returns to 1) on the same edge.
- Scan sequencer:
  - While `SKCTLS[1]` = 1, an 8-bit counter advances on each `enn` tick from 0 to SCAN_DIV-1, then wraps to 0.
  - `keybClk` is registered and equals 1 exactly while the counter = 0. It is therefore high for one `enn` period in every SCAN_DIV.
  - While `SKCTLS[1]` = 0, the counter is held at 0 and `keybClk` is forced to 0.
  - Re-enabling scanning starts from counter 0, with `keybClk` high on the first `enn` tick.
- Events are sampled only on edges where `enn` = 1. Each scan-core event is therefore counted exactly once.
- Key event (`setKey` = 1):
  - `kbcode` <= `kbD`, whether or not the interrupt is enabled.
  - If IRQEN[6] = 1, `nIrqst[0]` <= 0.
  - If `nIrqst[0]` was already 0, `nSkstat[1]` <= 0 (overrun).
- Break event (`setBreak` = 1): if IRQEN[7] = 1, `nIrqst[1]` <= 0.
- SKRES write: `nSkstat[1]` <= 1.
- `nSkstat[0]` <= ~`keyDown` on each `enn` tick.
- `nIrq` = AND of both `nIrqst` bits, registered.

## Timing
- `keybClk` rises one `clk` after the `enn` edge on which the counter reaches 0.
- Event to status: `kbcode`, `nIrqst` and `nSkstat` update on the `enn`-qualified edge that samples the event. `nIrq` follows one `clk` later.
- Simultaneous events, decided priorities:
  - IRQEN write clearing bit 6 together with `setKey`: the write wins. Pending stays clear, `kbcode` still loads, no overrun.
  - SKRES together with an overrunning `setKey`: the set wins and `nSkstat[1]` = 0.
  - SKCTL write with bit1 = 0 in the same cycle as the counter wrap: the counter goes to 0 and `keybClk` = 0 on the next edge.
- Disabling scanning mid-period leaves `kbcode`, pending bits and overrun untouched.
- `nReset` asserted mid-operation returns every output to its reset value immediately, independent of `clk`.

## Configuration
- `KEY_OVERRUN_EN`:
  - Defined: overrun detection and SKRES clearing behave as described above.
  - Undefined: the overrun flop is removed, `nSkstat[1]` is tied to 1, and `wrSkres` is ignored.

## Test plan
- Reset with scanning enabled: write SKCTL = 8'h03 → `SKCTLS` = 11; `keybClk` pulses high for one `enn` period every 114 `enn` ticks; count 3 consecutive periods.
- Write IRQEN = 8'h40; pulse `setKey` with `kbD` = 8'h3F → `kbcode` = 8'h3F, `nIrqst` = 10, `nIrq` = 0 one `clk` later.
- Second `setKey` with `kbD` = 8'h12 while the key IRQ is pending → `kbcode` = 8'h12, `nSkstat[1]` = 0. Then write SKRES → `nSkstat[1]` = 1. Skip when `KEY_OVERRUN_EN` is undefined; without the macro, `nSkstat[1]` stays 1.
- IRQEN = 8'hC0; `setBreak` → `nIrqst` = 01. Write IRQEN = 8'h40 → `nIrqst` = 11, `nIrq` = 1.
- IRQEN write of 8'h00 on the same edge as `setKey` with `kbD` = 8'h05 → `kbcode` = 8'h05, `nIrqst` = 11.
- Write SKCTL = 8'h00 at scan counter = 57 → `keybClk` stays 0. Re-write SKCTL = 8'h02 → `keybClk` is high on the next `enn` tick. Assert `nReset` mid-scan → all outputs return to reset values immediately.

Source files
------------

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl
//   Keyboard scan controller for the POKEY keyboard path. Produces the scan
//   strobe and SKCTL[1:0] for the keyboard scan core, captures key/break
//   events into KBCODE, IRQST[7:6] and SKSTAT[5]/[2], and drives the combined
//   keyboard interrupt request.
//
//   Build option: KEY_OVERRUN_EN
//     defined   - SKSTAT[5] overrun flag is kept, set by a key arriving while
//                 the key interrupt is still pending, cleared by SKRES.
//     undefined - no overrun flop; nSkstat[1] is tied high, wrSkres ignored.
//
//   Ports
//     clk, nReset         system clock, async active-low reset
//     enn                 1.79 MHz phase tick (one clk wide)
//     wrSkctl/wrIrqen/    CPU register write strobes, data on din
//     wrSkres, din
//     setKey, setBreak,   scan-core events and status, kbD valid with setKey
//     keyDown, kbD
//     keybClk             scan strobe, high one enn period every SCAN_DIV ticks
//     SKCTLS              SKCTL[1:0] (bit0 debounce, bit1 scan enable)
//     kbcode              KBCODE register
//     nIrqst              IRQST[7:6] active-low pending (1 = break, 0 = key)
//     nSkstat             {SKSTAT[5] overrun, SKSTAT[2] key down}, active-low
//     nIrq                active-low interrupt, registered AND of nIrqst

module key_scan_ctrl #(
   parameter int SCAN_DIV = 114          // enn ticks per scan step, 4..255
) (
   input  logic       clk,
   input  logic       nReset,
   input  logic       enn,
   input  logic       wrSkctl,
   input  logic       wrIrqen,
   input  logic       wrSkres,
   input  logic [7:0] din,
   input  logic       setKey,
   input  logic       setBreak,
   input  logic       keyDown,
   input  logic [7:0] kbD,
   output logic       keybClk,
   output logic [1:0] SKCTLS,
   output logic [7:0] kbcode,
   output logic [1:0] nIrqst,
   output logic [1:0] nSkstat,
   output logic       nIrq
);

   localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

   logic [7:0] scanCnt;
   logic [1:0] irqEn;        // {IRQEN[7], IRQEN[6]}
   logic [1:0] irqEnNext;
   logic       scanEnNext;
   logic       keyEvt;
   logic       brkEvt;
   logic       keyDownN;
   logic       overrunN;
   logic [3:0] unusedDin;

   assign unusedDin = din[5:2];

   // A write landing on the same edge as an event takes effect first, so a
   // disabling IRQEN write beats a simultaneous key/break.
   assign irqEnNext  = wrIrqen ? din[7:6] : irqEn;
   assign scanEnNext = wrSkctl ? din[1] : SKCTLS[1];
   assign keyEvt     = enn & setKey;
   assign brkEvt     = enn & setBreak;

   assign nSkstat = {overrunN, keyDownN};

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         SKCTLS   <= 2'b00;
         irqEn    <= 2'b00;
         scanCnt  <= 8'd0;
         keybClk  <= 1'b0;
         kbcode   <= 8'h00;
         nIrqst   <= 2'b11;
         keyDownN <= 1'b1;
         nIrq     <= 1'b1;
      end else begin
         if (wrSkctl)
            SKCTLS <= din[1:0];
         irqEn <= irqEnNext;

         if (!SKCTLS[1])
            scanCnt <= 8'd0;
         else if (enn)
            scanCnt <= (scanCnt == SCAN_LAST) ? 8'd0 : scanCnt + 8'd1;

         // Strobe follows counter==0 one clk later; an edge that turns scanning
         // off drops it immediately rather than letting it linger a cycle.
         keybClk <= scanEnNext & SKCTLS[1] & (scanCnt == 8'd0);

         if (keyEvt)
            kbcode <= kbD;

         if (!irqEnNext[0])
            nIrqst[0] <= 1'b1;
         else if (keyEvt)
            nIrqst[0] <= 1'b0;

         if (!irqEnNext[1])
            nIrqst[1] <= 1'b1;
         else if (brkEvt)
            nIrqst[1] <= 1'b0;

         if (enn)
            keyDownN <= ~keyDown;

         nIrq <= &nIrqst;
      end
   end

`ifdef KEY_OVERRUN_EN
   // Overrun: a key lands while the previous key interrupt is still pending
   // and is not being cancelled on this edge. Setting beats a same-edge SKRES.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)
         overrunN <= 1'b1;
      else if (keyEvt & irqEnNext[0] & ~nIrqst[0])
         overrunN <= 1'b0;
      else if (wrSkres)
         overrunN <= 1'b1;
   end
`else
   logic unusedSkres;
   assign unusedSkres = wrSkres;
   assign overrunN    = 1'b1;
`endif

endmodule

// File: tb/tb_key_scan_ctrl.sv
module tb_key_scan_ctrl;

   localparam int DIV = 114;

   logic       clk = 1'b0;
   logic       nReset;
   logic       enn;
   logic       wrSkctl, wrIrqen, wrSkres;
   logic [7:0] din;
   logic       setKey, setBreak, keyDown;
   logic [7:0] kbD;
   logic       keybClk;
   logic [1:0] SKCTLS;
   logic [7:0] kbcode;
   logic [1:0] nIrqst;
   logic [1:0] nSkstat;
   logic       nIrq;

   key_scan_ctrl #(.SCAN_DIV(DIV)) dut (
      .clk(clk), .nReset(nReset), .enn(enn),
      .wrSkctl(wrSkctl), .wrIrqen(wrIrqen), .wrSkres(wrSkres), .din(din),
      .setKey(setKey), .setBreak(setBreak), .keyDown(keyDown), .kbD(kbD),
      .keybClk(keybClk), .SKCTLS(SKCTLS), .kbcode(kbcode),
      .nIrqst(nIrqst), .nSkstat(nSkstat), .nIrq(nIrq)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ennPh = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: register contents as the CPU would see them.
   logic [1:0] mEn;
   bit         mPendKey, mPendBrk, mOvr, mKeyDn;
   logic [7:0] mKb;

   typedef struct {
      int         due;
      bit         kind;     // 0: status registers, 1: interrupt line
      logic [7:0] kb;
      logic [1:0] irqst;
      logic [1:0] skstat;
      logic       irq;
   } exp_t;

   exp_t sbq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         if (e.kind == 1'b0) begin
            check("kbcode", 32'(kbcode), 32'(e.kb));
            check("nIrqst", 32'(nIrqst), 32'(e.irqst));
            check("nSkstat", 32'(nSkstat), 32'(e.skstat));
         end else begin
            check("nIrq", 32'(nIrq), 32'(e.irq));
         end
      end
   end

   task automatic modelReset();
      mEn = 2'b00; mPendKey = 0; mPendBrk = 0; mOvr = 0; mKeyDn = 0; mKb = 8'h00;
   endtask

   task automatic clkStep();
      @(posedge clk);
      #1;
      wrSkctl = 0; wrIrqen = 0; wrSkres = 0; setKey = 0; setBreak = 0;
      ennPh = (ennPh + 1) % 4;
      enn   = (ennPh == 0);
   endtask

   task automatic waitEnn();
      while (!enn) clkStep();
   endtask

   task automatic waitNoEnn();
      while (enn) clkStep();
   endtask

   // One CPU/scan-core transaction; the model's view is queued for the monitor.
   task automatic op(input bit onEnn, input bit wI, input logic [7:0] wd, input bit sR,
                     input bit k, input logic [7:0] kd, input bit b, input bit kdn);
      logic [1:0] newEn;
      exp_t       e;
      if (onEnn) waitEnn(); else waitNoEnn();
      wrIrqen  = wI;
      din      = wI ? wd : 8'($urandom);
      wrSkres  = sR;
      setKey   = k;
      kbD      = kd;
      setBreak = b;
      if (onEnn) keyDown = kdn;

      newEn = wI ? wd[7:6] : mEn;
      if (onEnn && k) begin
         mKb = kd;
`ifdef KEY_OVERRUN_EN
         if (mPendKey && newEn[0]) mOvr = 1;
         else if (sR) mOvr = 0;
`endif
         if (newEn[0]) mPendKey = 1;
      end
`ifdef KEY_OVERRUN_EN
      else if (sR) mOvr = 0;
`endif
      if (onEnn && b && newEn[1]) mPendBrk = 1;
      if (!newEn[0]) mPendKey = 0;
      if (!newEn[1]) mPendBrk = 0;
      if (onEnn) mKeyDn = kdn;
      mEn = newEn;

      clkStep();
      e.due = cyc; e.kind = 0; e.kb = mKb;
      e.irqst  = {~mPendBrk, ~mPendKey};
      e.skstat = {~mOvr, ~mKeyDn};
      e.irq    = 1'b1;
      sbq.push_back(e);
      e.due = cyc + 1; e.kind = 1;
      e.irq = ~(mPendKey | mPendBrk);
      sbq.push_back(e);
   endtask

   // SKCTL write placed so that at least two clks remain before the next enn.
   task automatic wrCtl(input logic [7:0] d);
      waitEnn();
      clkStep();
      wrSkctl = 1; din = d;
      clkStep();
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, " keybClk"}, 32'(keybClk), 32'd0);
      check({tag, " SKCTLS"},  32'(SKCTLS),  32'd0);
      check({tag, " kbcode"},  32'(kbcode),  32'h00);
      check({tag, " nIrqst"},  32'(nIrqst),  32'd3);
      check({tag, " nSkstat"}, 32'(nSkstat), 32'd3);
      check({tag, " nIrq"},    32'(nIrq),    32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ticks, lastRise, rises, highTicks, seen;
      bit prevK, sawHigh;
      nReset = 0; enn = 1; ennPh = 0;
      wrSkctl = 0; wrIrqen = 0; wrSkres = 0; din = 0;
      setKey = 0; setBreak = 0; keyDown = 0; kbD = 0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      nReset = 1;

      // Scan strobe: period and width in enn ticks.
      wrCtl(8'h03);
      check("SKCTLS after write", 32'(SKCTLS), 32'd3);
      ticks = 0; lastRise = -1; rises = 0; highTicks = 0; prevK = keybClk;
      for (int i = 0; i < 3000 && rises < 3; i++) begin
         if (enn) begin
            ticks++;
            if (keybClk) highTicks++;
         end
         clkStep();
         if (keybClk && !prevK) begin
            if (lastRise >= 0) begin
               check("scan period", 32'(ticks - lastRise), 32'(DIV));
               check("scan width", 32'(highTicks), 32'd1);
               rises++;
            end
            lastRise  = ticks;
            highTicks = 0;
         end
         prevK = keybClk;
      end
      check("scan periods seen", 32'(rises), 32'd3);

      // Directed event sequence.
      op(1, 1, 8'h40, 0, 0, 8'h00, 0, 0);
      op(1, 0, 8'h00, 0, 1, 8'h3F, 0, 1);
      op(1, 0, 8'h00, 0, 1, 8'h12, 0, 1);
      op(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      op(1, 1, 8'h00, 0, 0, 8'h00, 0, 0);
      op(1, 1, 8'hC0, 0, 0, 8'h00, 0, 0);
      op(1, 0, 8'h00, 0, 0, 8'h00, 1, 0);
      op(1, 1, 8'h40, 0, 0, 8'h00, 0, 0);
      op(1, 0, 8'h00, 0, 1, 8'h77, 0, 0);
      op(1, 1, 8'h00, 0, 1, 8'h05, 0, 0);
      // Overrunning key together with SKRES: set wins.
      op(1, 1, 8'h40, 0, 1, 8'h21, 0, 0);
      op(1, 0, 8'h00, 1, 1, 8'h22, 0, 1);
      // Event on a non-enn cycle must be ignored.
      op(0, 0, 8'h00, 0, 1, 8'hEE, 1, 0);

      // Randomized transactions.
      for (int i = 0; i < 120; i++) begin
         bit onE, wI, sR;
         onE = ($urandom_range(0, 3) != 0);
         wI  = ($urandom_range(0, 3) == 0);
         sR  = !wI && ($urandom_range(0, 4) == 0);
         op(onE, wI, 8'($urandom), sR, 1'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
      end
      repeat (4) clkStep();
      check("scoreboard drained", 32'(sbq.size()), 32'd0);

      // Disable scanning mid-period at counter 57.
      prevK = keybClk; seen = 0;
      for (int i = 0; i < 2000 && seen == 0; i++) begin
         clkStep();
         if (keybClk && !prevK) seen = 1;
         prevK = keybClk;
      end
      check("sync to strobe", 32'(seen), 32'd1);
      ticks = 0;
      for (int i = 0; i < 1000 && ticks < 57; i++) begin
         if (enn) ticks++;
         clkStep();
      end
      waitNoEnn();
      wrSkctl = 1; din = 8'h00;
      clkStep();
      check("SKCTLS disabled", 32'(SKCTLS), 32'd0);
      sawHigh = 0;
      for (int i = 0; i < 2 * DIV * 4; i++) begin
         clkStep();
         if (keybClk) sawHigh = 1;
      end
      check("keybClk while disabled", 32'(sawHigh), 32'd0);

      wrCtl(8'h02);
      waitEnn();
      check("keybClk on first enn after enable", 32'(keybClk), 32'd1);

      // Load state, then reset mid-scan.
      op(1, 1, 8'hC0, 0, 1, 8'hAA, 1, 1);
      repeat (10) clkStep();
      check("scoreboard drained 2", 32'(sbq.size()), 32'd0);
      @(posedge clk);
      #3;
      nReset = 0;
      #1;
      checkResetOutputs("async reset");
      modelReset();
      #20;
      nReset = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
